// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// -----------------------------------------------------------------------------
// Front-end PS/2 receiver. Raw PS2_CLK / PS2_DAT pads are synchronised and
// glitch-filtered, then 11-bit device-to-host frames (start, 8 data bits
// LSB-first, odd parity, stop) are deframed and each good byte is offered to
// the scancode controlpath over a valid/ready holding register.
// Parity, framing, timeout and overrun problems are reported as registered
// single-cycle pulses. Receive only; the pads are never driven.
//
// Parameters
//   FILTER_LEN      cycles a synchronised line must hold a new level before
//                   the filter accepts it (>= 2)
//   TIMEOUT_CYCLES  longest gap between PS/2 clock falls inside a frame
//                   before the frame is abandoned (>= 2)
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   ps2_clk_in   in   raw PS2_CLK pad (asynchronous)
//   ps2_dat_in   in   raw PS2_DAT pad (asynchronous)
//   rx_data      out  received byte, stable while rx_valid is high
//   rx_valid     out  byte available, held until accepted
//   rx_ready     in   consumer accepts on rx_valid & rx_ready
//   err_parity   out  pulse: parity mismatch, byte dropped
//   err_frame    out  pulse: start bit 1 or stop bit 0, byte dropped
//   err_timeout  out  pulse: frame abandoned after TIMEOUT_CYCLES without a fall
//   err_overrun  out  pulse: good byte arrived while holding reg full, not accepted
//   busy         out  high whenever the deframer is not idle
// -----------------------------------------------------------------------------

// ps2_line_filter
// Two-flop synchroniser followed by a persistence filter for one PS/2 line.
// The filtered level only follows the synchronised level once the two have
// disagreed for FILTER_LEN consecutive cycles; any agreement restarts the
// count, so pulses shorter than FILTER_LEN cycles never reach the output.
//
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   pad    in   raw asynchronous line
//   level  out  synchronised, filtered line level (idles high)
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic pad,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] hold_cnt;

    // Synchroniser; both stages come out of reset at the idle bus level so
    // no spurious edge is seen when reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= pad;
            sync_b <= sync_a;
        end
    end

    // The counter value is the number of cycles the synchronised line has
    // already disagreed with the filtered level; the cycle that would make
    // it FILTER_LEN is the one that commits the new level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level    <= 1'b1;
            hold_cnt <= '0;
        end else if (sync_b == level) begin
            hold_cnt <= '0;
        end else if (hold_cnt == CNT_LAST) begin
            level    <= sync_b;
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          clk_filt;
    logic          clk_filt_d;
    logic          dat_filt;
    logic          fall;

    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic          start_en;
    logic          shift_en;
    logic          par_en;
    logic          frame_err_set;
    logic          parity_err_set;
    logic          deliver_set;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock (clock),
        .reset (reset),
        .pad   (ps2_clk_in),
        .level (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clock (clock),
        .reset (reset),
        .pad   (ps2_dat_in),
        .level (dat_filt)
    );

    // Falling-edge detector on the filtered PS/2 clock. The delayed copy
    // resets high so the bus idling high produces no edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    // Timeout fires on the cycle the gap since the last fall would reach
    // TIMEOUT_CYCLES. A fall in the same cycle always wins.
    assign timeout_hit = (state != S_IDLE) && !fall && (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the deframer only moves on a filtered clock fall,
    // except for the timeout escape back to idle.
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   state_next = dat_filt ? S_IDLE : S_DATA;
                S_DATA:   state_next = (bit_cnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: state_next = S_STOP;
                S_STOP:   state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Output / control decode. Framing and parity are judged independently
    // at the stop bit so both pulses can fire for the same frame.
    always_comb begin
        busy           = (state != S_IDLE);
        start_en       = 1'b0;
        shift_en       = 1'b0;
        par_en         = 1'b0;
        frame_err_set  = 1'b0;
        parity_err_set = 1'b0;
        deliver_set    = 1'b0;
        if (fall) begin
            case (state)
                S_IDLE: begin
                    start_en      = ~dat_filt;
                    frame_err_set = dat_filt;
                end
                S_DATA: begin
                    shift_en = 1'b1;
                end
                S_PARITY: begin
                    par_en = 1'b1;
                end
                S_STOP: begin
                    frame_err_set  = ~dat_filt;
                    parity_err_set = ~par_ok;
                    deliver_set    = dat_filt & par_ok;
                end
                default: begin
                    start_en = 1'b0;
                end
            endcase
        end
    end

    // Deframing datapath: shift register, bit counter and parity verdict.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_ok  <= 1'b0;
        end else begin
            if (start_en) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {dat_filt, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_en) begin
                par_ok <= (^shreg) ^ dat_filt;
            end
        end
    end

    // Inter-edge watchdog: counts only while a frame is in progress and
    // restarts on every fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if ((state == S_IDLE) || fall || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Error pulses are registered so each lasts exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_parity  <= parity_err_set;
            err_frame   <= frame_err_set;
            err_timeout <= timeout_hit;
            err_overrun <= deliver_set & rx_valid & ~rx_ready;
        end
    end

    // Holding register. A new byte may replace the held one only if the held
    // one is being accepted in the same cycle; otherwise the new byte is lost
    // and flagged as an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (deliver_set) begin
            if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx
// Self-checking bench for ps2_frame_rx. A PS/2 device model drives frames on
// the pads; bytes expected to be delivered are queued when sent and compared
// when the consumer handshake takes them. Error pulses are counted and their
// widths checked by a monitor.
module tb_ps2_frame_rx;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    logic       clock;
    logic       reset;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_parity;
    logic       err_frame;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    int         n_checks;
    int         n_fails;
    logic [7:0] sb_queue[$];
    int         err_cnt[4];
    int         err_width[4];
    int         exp_err[4];
    logic [3:0] err_prev;
    string      err_name[4] = '{"err_parity", "err_frame", "err_timeout", "err_overrun"};

    ps2_frame_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side and error-pulse monitor, sampled on the falling edge.
    always @(negedge clock) begin
        logic [3:0] err_now;
        logic [7:0] exp_byte;
        err_now = {err_overrun, err_timeout, err_frame, err_parity};
        if (!reset) begin
            err_prev = '0;
            for (int k = 0; k < 4; k++) err_width[k] = 0;
        end else begin
            if (rx_valid && rx_ready) begin
                if (sb_queue.size() == 0) begin
                    check_output("sb unexpected byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_byte = sb_queue.pop_front();
                    check_output("sb rx_data", {24'h0, rx_data}, {24'h0, exp_byte});
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (err_now[k]) begin
                    if (!err_prev[k]) begin
                        err_cnt[k]++;
                        err_width[k] = 0;
                    end
                    err_width[k]++;
                end else if (err_prev[k]) begin
                    check_output({err_name[k], " width"}, err_width[k], 1);
                end
            end
            err_prev = err_now;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Drives the first nfalls bits of a frame. Each bit is set while the
    // PS/2 clock is high and taken on the fall; the clock is left low after
    // the last fall. Optional glitch: a FL-1 cycle low pulse in every high half.
    task automatic send_bits(input logic [10:0] frame, input int nfalls, input bit glitch);
        for (int i = 0; i < nfalls; i++) begin
            ps2_dat_in = frame[i];
            if (glitch) begin
                wait_cycles(10);
                ps2_clk_in = 1'b0;
                wait_cycles(FL - 1);
                ps2_clk_in = 1'b1;
                wait_cycles(HALF - 10 - (FL - 1));
            end else begin
                wait_cycles(HALF);
            end
            ps2_clk_in = 1'b0;
            if (i != nfalls - 1) begin
                wait_cycles(HALF);
                ps2_clk_in = 1'b1;
            end
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] data, input bit par_flip,
                                               input bit stop_bit);
        return {stop_bit, (~^data) ^ par_flip, data, 1'b0};
    endfunction

    task automatic apply_stimulus(input logic [7:0] data, input bit par_flip, input bit stop_bit,
                                  input bit push, input bit glitch);
        if (push) sb_queue.push_back(data);
        send_bits(make_frame(data, par_flip, stop_bit), 11, glitch);
        wait_cycles(HALF);
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic check_errs(input string tag);
        for (int k = 0; k < 4; k++) begin
            check_output({tag, " ", err_name[k], " count"}, err_cnt[k], exp_err[k]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        n_checks   = 0;
        n_fails    = 0;
        for (int k = 0; k < 4; k++) begin
            err_cnt[k] = 0;
            exp_err[k] = 0;
            err_width[k] = 0;
        end
        err_prev   = '0;
        reset      = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        rx_ready   = 1'b1;
        wait_cycles(5);
        check_output("reset rx_data", {24'h0, rx_data}, 32'h0);
        check_output("reset rx_valid", {31'h0, rx_valid}, 32'h0);
        check_output("reset busy", {31'h0, busy}, 32'h0);
        check_output("reset err_*", {28'h0, err_overrun, err_timeout, err_frame, err_parity}, 32'h0);
        reset = 1'b1;
        wait_cycles(20);
        check_output("idle busy", {31'h0, busy}, 32'h0);

        // Test 1: single good frame, consumer always ready.
        $display("[TB] test 1: frame 0x1D");
        apply_stimulus(8'h1D, 1'b0, 1'b1, 1'b1, 1'b0);
        check_output("t1 rx_valid", {31'h0, rx_valid}, 32'h0);
        check_errs("t1");

        // Test 2: two frames with the consumer stalled.
        $display("[TB] test 2: overrun");
        rx_ready = 1'b0;
        apply_stimulus(8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(8'h1D, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_err[3]++;
        check_output("t2 rx_data held", {24'h0, rx_data}, 32'hF0);
        check_output("t2 rx_valid held", {31'h0, rx_valid}, 32'h1);
        check_errs("t2");
        rx_ready = 1'b1;
        @(negedge clock);
        check_output("t2 rx_valid before accept", {31'h0, rx_valid}, 32'h1);
        @(negedge clock);
        check_output("t2 rx_valid after accept", {31'h0, rx_valid}, 32'h0);
        check_output("t2 rx_data kept", {24'h0, rx_data}, 32'hF0);
        tick();

        // Test 3: bad parity.
        $display("[TB] test 3: parity error");
        apply_stimulus(8'hE0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_err[0]++;
        check_output("t3 rx_valid", {31'h0, rx_valid}, 32'h0);
        check_errs("t3");

        // Test 4: stop bit low, then a good frame.
        $display("[TB] test 4: framing error");
        apply_stimulus(8'h1D, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_err[1]++;
        check_output("t4 rx_valid", {31'h0, rx_valid}, 32'h0);
        check_errs("t4a");
        apply_stimulus(8'h1D, 1'b0, 1'b1, 1'b1, 1'b0);
        check_errs("t4b");

        // Test 5: clock stops after 4 data bits. Pad fall reaches the deframer
        // after 2 sync + FL filter cycles, the fall is consumed on the next
        // edge, TO further edges later the registered pulse appears.
        $display("[TB] test 5: timeout");
        send_bits(make_frame(8'hA5, 1'b0, 1'b1), 5, 1'b0);
        n = 0;
        while (!err_timeout && n < 3000) begin
            tick();
            n++;
            if (n == 50) check_output("t5 busy mid-frame", {31'h0, busy}, 32'h1);
        end
        check_output("t5 timeout latency", n, FL + TO + 3);
        check_output("t5 busy after timeout", {31'h0, busy}, 32'h0);
        exp_err[2]++;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        wait_cycles(HALF);
        apply_stimulus(8'h29, 1'b0, 1'b1, 1'b1, 1'b0);
        check_errs("t5");

        // Test 6: sub-threshold glitches, then reset mid-frame.
        $display("[TB] test 6: glitches and reset");
        apply_stimulus(8'h1D, 1'b0, 1'b1, 1'b1, 1'b1);
        check_errs("t6a");
        rx_ready = 1'b0;
        apply_stimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("t6 rx_valid before reset", {31'h0, rx_valid}, 32'h1);
        send_bits(make_frame(8'h3C, 1'b0, 1'b1), 4, 1'b0);
        wait_cycles(20);
        check_output("t6 busy before reset", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check_output("t6 reset rx_valid", {31'h0, rx_valid}, 32'h0);
        check_output("t6 reset rx_data", {24'h0, rx_data}, 32'h0);
        check_output("t6 reset busy", {31'h0, busy}, 32'h0);
        check_output("t6 reset err_*", {28'h0, err_overrun, err_timeout, err_frame, err_parity}, 32'h0);
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        wait_cycles(20);
        reset = 1'b1;
        wait_cycles(20);
        rx_ready = 1'b1;
        apply_stimulus(8'h1D, 1'b0, 1'b1, 1'b1, 1'b0);
        check_errs("t6b");

        wait_cycles(10);
        check_output("sb drained", sb_queue.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
